// File: rtl/glip_rx_deframer.sv
// ---------------------------------------------------------------------------
// glip_rx_deframer
//
// Splits the host->FPGA GLIP word stream into length-framed packets. Each
// packet begins with a header word holding the payload length L, followed by
// L payload words. Payload words pass through a single output register with
// first/last markers. Headers with L > MAX_LEN are consumed together with
// their payload and reported through a one-cycle error pulse. A header of 0
// is a keepalive and produces nothing.
//
// Ports
//   clk           logic clock, shared with the GLIP fifo_in_* side
//   rst_n         asynchronous active-low reset
//   in_data       incoming word (GLIP fifo_in_data)
//   in_valid      incoming word valid (GLIP fifo_in_valid)
//   in_ready      incoming word consumed this cycle (GLIP fifo_in_ready)
//   out_data      payload word
//   out_valid     payload word valid
//   out_ready     downstream accepts the payload word
//   out_first     out_data is the first payload word of its packet
//   out_last      out_data is the last payload word of its packet
//   err_oversize  one-cycle pulse after an oversized header was accepted
//   pkt_count     packets fully delivered, wraps at 16 bits
//   drop_count    packets dropped as oversized, wraps at 16 bits
// ---------------------------------------------------------------------------
module glip_rx_deframer #(
    parameter int WIDTH   = 16,
    parameter int MAX_LEN = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_first,
    output logic             out_last,
    output logic             err_oversize,
    output logic [15:0]      pkt_count,
    output logic [15:0]      drop_count
);

    localparam logic [WIDTH-1:0] MaxLenW = WIDTH'(MAX_LEN);
    localparam logic [WIDTH-1:0] OneW    = WIDTH'(1);

    typedef enum logic [1:0] {
        ST_HDR,
        ST_PAYLOAD,
        ST_DROP
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic             first_pend_q, first_pend_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_first_q, out_first_d;
    logic             out_last_q, out_last_d;
    logic             err_q, err_d;
    logic [15:0]      pkt_cnt_q, pkt_cnt_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;

    logic             in_fire;
    logic             out_fire;

    // State and datapath registers; reset abandons any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HDR;
            remaining_q  <= '0;
            first_pend_q <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_first_q  <= 1'b0;
            out_last_q   <= 1'b0;
            err_q        <= 1'b0;
            pkt_cnt_q    <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            first_pend_q <= first_pend_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_first_q  <= out_first_d;
            out_last_q   <= out_last_d;
            err_q        <= err_d;
            pkt_cnt_q    <= pkt_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Next-state logic. The output register may be drained and refilled in
    // the same cycle, so the drain is applied first and a PAYLOAD load then
    // overrides it.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        first_pend_d = first_pend_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_first_d  = out_first_q;
        out_last_d   = out_last_q;
        err_d        = 1'b0;
        pkt_cnt_d    = pkt_cnt_q;
        drop_cnt_d   = drop_cnt_q;

        out_fire = out_valid_q && out_ready;

        // Only PAYLOAD needs room in the output register; headers and dropped
        // words are always consumed.
        if (state_q == ST_PAYLOAD) begin
            in_ready = !out_valid_q || out_ready;
        end else begin
            in_ready = 1'b1;
        end
        in_fire = in_valid && in_ready;

        if (out_fire) begin
            out_valid_d = 1'b0;
            if (out_last_q) begin
                pkt_cnt_d = pkt_cnt_q + 16'd1;
            end
        end

        case (state_q)
            ST_HDR: begin
                if (in_fire && (in_data != '0)) begin
                    remaining_d = in_data;
                    if (in_data <= MaxLenW) begin
                        first_pend_d = 1'b1;
                        state_d      = ST_PAYLOAD;
                    end else begin
                        err_d      = 1'b1;
                        drop_cnt_d = drop_cnt_q + 16'd1;
                        state_d    = ST_DROP;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (in_fire) begin
                    out_data_d   = in_data;
                    out_valid_d  = 1'b1;
                    out_first_d  = first_pend_q;
                    out_last_d   = (remaining_q == OneW);
                    first_pend_d = 1'b0;
                    remaining_d  = remaining_q - OneW;
                    if (remaining_q == OneW) begin
                        state_d = ST_HDR;
                    end
                end
            end
            ST_DROP: begin
                if (in_fire) begin
                    remaining_d = remaining_q - OneW;
                    if (remaining_q == OneW) begin
                        state_d = ST_HDR;
                    end
                end
            end
            default: begin
                state_d = ST_HDR;
            end
        endcase
    end

    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign out_first    = out_first_q;
    assign out_last     = out_last_q;
    assign err_oversize = err_q;
    assign pkt_count    = pkt_cnt_q;
    assign drop_count   = drop_cnt_q;

endmodule

// File: tb/tb_glip_rx_deframer.sv
// ---------------------------------------------------------------------------
// tb_glip_rx_deframer
//
// Testbench for glip_rx_deframer. Packets are described at the packet level:
// each one pushes its expected payload beats into a queue, and a monitor
// pops a beat for every output handshake and compares data and markers. The
// same monitor tracks expected packet/drop counters, the error pulse, output
// stability while stalled and the reason for in_ready being low. Directed
// literal checks pin latency, reset values and counter totals.
// ---------------------------------------------------------------------------
module tb_glip_rx_deframer;

    localparam int WIDTH   = 16;
    localparam int MAX_LEN = 256;

    typedef struct {
        logic [15:0] data;
        logic        first;
        logic        last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [WIDTH-1:0]  in_data;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_first;
    logic              out_last;
    logic              err_oversize;
    logic [15:0]       pkt_count;
    logic [15:0]       drop_count;

    beat_t expQ[$];
    int    checks     = 0;
    int    fails      = 0;
    int    expPkt     = 0;
    int    expDrop    = 0;
    int    errPulses  = 0;
    bit    errExp     = 1'b0;
    bit    toggleMode = 1'b0;

    glip_rx_deframer #(
        .WIDTH   (WIDTH),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_first    (out_first),
        .out_last     (out_last),
        .err_oversize (err_oversize),
        .pkt_count    (pkt_count),
        .drop_count   (drop_count)
    );

    // Free-running clock: posedges at 5, 15, ...; inputs change on negedges.
    always #5 clk = ~clk;

    // Count every cycle in which the error pulse is seen outside reset.
    always @(negedge clk) begin
        if (rst_n && err_oversize) begin
            errPulses++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Offer one word until it is accepted; reports the output register state
    // just after the accepting edge.
    task automatic applyStimulus(input logic [15:0] w, output logic vAfter,
                                 output logic [15:0] dAfter);
        bit done;
        int tries;
        done  = 1'b0;
        tries = 0;
        while (!done) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_data   = w;
            out_ready = toggleMode ? ~out_ready : 1'b1;
            #1;
            done = in_ready;
            @(posedge clk);
            tries++;
            if (!done && tries >= 64) begin
                checks++;
                fails++;
                $display("[TB] FAIL accept_timeout: word 0x%0h not accepted after %0d cycles", w, tries);
                done = 1'b1;
            end
        end
        #1;
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
        vAfter   = out_valid;
        dAfter   = out_data;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = toggleMode ? ~out_ready : 1'b1;
        end
    endtask

    // Model: a packet of length L with 1 <= L <= MAX_LEN yields L beats whose
    // data is base+i, first on i==0 and last on i==L-1; anything else none.
    task automatic expectPacket(input int len, input logic [15:0] base);
        beat_t b;
        if (len >= 1 && len <= MAX_LEN) begin
            for (int i = 0; i < len; i++) begin
                b.data  = base + 16'(i);
                b.first = (i == 0);
                b.last  = (i == len - 1);
                expQ.push_back(b);
            end
        end
    endtask

    task automatic sendHeader(input logic [15:0] len, output logic vAfter);
        logic [15:0] d;
        applyStimulus(len, vAfter, d);
        if (int'(len) > MAX_LEN) begin
            expDrop++;
            errExp = 1'b1;
        end
    endtask

    task automatic sendPacket(input int len, input logic [15:0] base, input int nSend);
        logic        v;
        logic [15:0] d;
        expectPacket(len, base);
        sendHeader(16'(len), v);
        for (int i = 0; i < nSend; i++) begin
            applyStimulus(base + 16'(i), v, d);
        end
    endtask

    // Monitor: samples two units before each posedge, when outputs and the
    // bench-driven out_ready are both settled for the coming edge.
    initial begin
        bit    stalled;
        beat_t held;
        beat_t e;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                stalled = 1'b0;
                continue;
            end
            checkOutput("pkt_count", 32'(pkt_count), 32'(expPkt));
            checkOutput("drop_count", 32'(drop_count), 32'(expDrop));
            checkOutput("err_oversize", 32'(err_oversize), 32'(errExp));
            errExp = 1'b0;
            if (stalled) begin
                checkOutput("stall_valid", 32'(out_valid), 32'd1);
                checkOutput("stall_data", 32'(out_data), 32'(held.data));
                checkOutput("stall_first", 32'(out_first), 32'(held.first));
                checkOutput("stall_last", 32'(out_last), 32'(held.last));
            end
            if (!in_ready) begin
                checkOutput("in_ready_low_cause", 32'(out_valid && !out_ready), 32'd1);
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpected_beat: got data 0x%0h, expected no beat", out_data);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("beat_data", 32'(out_data), 32'(e.data));
                    checkOutput("beat_first", 32'(out_first), 32'(e.first));
                    checkOutput("beat_last", 32'(out_last), 32'(e.last));
                    if (e.last) begin
                        expPkt++;
                    end
                end
            end
            stalled    = out_valid && !out_ready;
            held.data  = out_data;
            held.first = out_first;
            held.last  = out_last;
        end
    end

    initial begin
        logic        v;
        logic [15:0] d;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_data", 32'(out_data), 32'd0);
        checkOutput("reset_pkt_count", 32'(pkt_count), 32'd0);
        checkOutput("reset_drop_count", 32'(drop_count), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Three-word packet with 1-cycle latency per word.
        expectPacket(3, 16'hA000);
        sendHeader(16'd3, v);
        checkOutput("t1_hdr_no_output", 32'(v), 32'd0);
        applyStimulus(16'hA000, v, d);
        checkOutput("t1_a_valid", 32'(v), 32'd1);
        checkOutput("t1_a_data", 32'(d), 32'hA000);
        applyStimulus(16'hA001, v, d);
        checkOutput("t1_b_data", 32'(d), 32'hA001);
        applyStimulus(16'hA002, v, d);
        checkOutput("t1_c_data", 32'(d), 32'hA002);
        idle(4);
        #4;
        checkOutput("t1_pkt_count", 32'(pkt_count), 32'd1);

        // Keepalive then a single-beat packet.
        sendHeader(16'd0, v);
        checkOutput("t2_keepalive_no_output", 32'(v), 32'd0);
        expectPacket(1, 16'h55AA);
        sendHeader(16'd1, v);
        applyStimulus(16'h55AA, v, d);
        checkOutput("t2_beat_data", 32'(d), 32'h55AA);
        checkOutput("t2_first", 32'(out_first), 32'd1);
        checkOutput("t2_last", 32'(out_last), 32'd1);
        idle(4);
        #4;
        checkOutput("t2_pkt_count", 32'(pkt_count), 32'd2);
        checkOutput("t2_drop_count", 32'(drop_count), 32'd0);

        // Oversized packet is dropped, then a normal packet follows.
        sendPacket(MAX_LEN + 1, 16'h1000, MAX_LEN + 1);
        sendPacket(2, 16'hB000, 2);
        idle(4);
        #4;
        checkOutput("t3_drop_count", 32'(drop_count), 32'd1);
        checkOutput("t3_pkt_count", 32'(pkt_count), 32'd3);
        checkOutput("t3_err_pulses", 32'(errPulses), 32'd1);

        // Back-pressure with out_ready toggling every cycle.
        toggleMode = 1'b1;
        sendPacket(4, 16'hC000, 4);
        idle(10);
        toggleMode = 1'b0;
        idle(4);
        #4;
        checkOutput("t4_pkt_count", 32'(pkt_count), 32'd4);

        // Reset in the middle of a packet.
        expectPacket(5, 16'hD000);
        sendHeader(16'd5, v);
        applyStimulus(16'hD000, v, d);
        applyStimulus(16'hD001, v, d);
        checkOutput("t5_pre_reset_valid", 32'(v), 32'd1);
        #1;
        rst_n = 1'b0;
        expQ.delete();
        expPkt  = 0;
        expDrop = 0;
        errExp  = 1'b0;
        #1;
        checkOutput("t5_reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("t5_reset_pkt_count", 32'(pkt_count), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expectPacket(1, 16'hE000);
        sendHeader(16'd1, v);
        applyStimulus(16'hE000, v, d);
        checkOutput("t5_z_data", 32'(d), 32'hE000);
        checkOutput("t5_z_first", 32'(out_first), 32'd1);
        checkOutput("t5_z_last", 32'(out_last), 32'd1);
        idle(4);
        #4;
        checkOutput("t5_pkt_count", 32'(pkt_count), 32'd1);
        checkOutput("t5_drop_count", 32'(drop_count), 32'd0);

        // Back-to-back packets: one empty output cycle per header.
        expectPacket(2, 16'hF000);
        expectPacket(1, 16'hF100);
        sendHeader(16'd2, v);
        checkOutput("t6_hdr2_valid", 32'(v), 32'd0);
        applyStimulus(16'hF000, v, d);
        checkOutput("t6_a_valid", 32'(v), 32'd1);
        applyStimulus(16'hF001, v, d);
        checkOutput("t6_b_data", 32'(d), 32'hF001);
        sendHeader(16'd1, v);
        checkOutput("t6_hdr1_valid", 32'(v), 32'd0);
        applyStimulus(16'hF100, v, d);
        checkOutput("t6_c_data", 32'(d), 32'hF100);
        idle(4);
        #4;
        checkOutput("t6_pkt_count", 32'(pkt_count), 32'd3);
        checkOutput("all_beats_delivered", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
